// File: rtl/anton_neopixel_decoder.sv
// WS2812 receive decoder: synchronises the serial line, classifies high-pulse widths into bits,
// assembles MSB-first bytes and reports frame boundaries at the latch gap.
module anton_neopixel_decoder #(
    parameter int ONE_MIN   = 4,
    parameter int HIGH_MAX  = 12,
    parameter int RESET_LOW = 350,
    parameter int CNT_W     = 10
) (
    input  logic        clk7mhz,
    input  logic        reset,
    input  logic        neoData,
    output logic [7:0]  dataOut,
    output logic        dataValid,
    output logic [13:0] byteIndex,
    output logic        frameDone,
    output logic [13:0] frameBytes,
    output logic        error,
    output logic        busy
);

    localparam logic [CNT_W-1:0] ONE_MIN_C  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] LOW_LAST_C = CNT_W'(RESET_LOW - 1);
    localparam logic [13:0]      BYTE_MAX   = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t            state_r;
    logic [1:0]        sync_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [6:0]        shift_r;
    logic [2:0]        bit_cnt_r;
    logic [13:0]       byte_cnt_r;
    logic              byte_pend_r;
    logic              fault_seen_r;
    logic              frame_clean_r;
    logic              line_s;
    logic              bit_val_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Synchronised line level and the bit value implied by the current high-pulse count
    always_comb begin
        line_s    = sync_r[1];
        bit_val_s = (cnt_r >= ONE_MIN_C);
    end

    // Synchroniser, pulse-width FSM, byte assembly and frame/error bookkeeping
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            state_r       <= ST_SYNC;
            sync_r        <= 2'b00;
            cnt_r         <= '0;
            shift_r       <= 7'd0;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 14'd0;
            byte_pend_r   <= 1'b0;
            fault_seen_r  <= 1'b0;
            frame_clean_r <= 1'b0;
            dataOut       <= 8'd0;
            dataValid     <= 1'b0;
            byteIndex     <= 14'd0;
            frameDone     <= 1'b0;
            frameBytes    <= 14'd0;
            error         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], neoData};
            dataValid <= 1'b0;
            frameDone <= 1'b0;

            // A fault-free frame releases the sticky error one cycle after its frameDone
            if (frameDone && frame_clean_r) begin
                error <= 1'b0;
            end

            if (byte_pend_r) begin
                byte_pend_r <= 1'b0;
                dataValid   <= 1'b1;
                byteIndex   <= byte_cnt_r;
                if (byte_cnt_r == BYTE_MAX) begin
                    error        <= 1'b1;
                    fault_seen_r <= 1'b1;
                end else begin
                    byte_cnt_r <= byte_cnt_r + 14'd1;
                end
            end

            case (state_r)
                ST_SYNC: begin
                    busy <= 1'b0;
                    if (line_s) begin
                        cnt_r <= '0;
                    end else if (cnt_r >= LOW_LAST_C) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                ST_IDLE: begin
                    if (line_s) begin
                        state_r <= ST_HIGH;
                        cnt_r   <= CNT_W'(1);
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (line_s) begin
                        if (cnt_r >= HIGH_MAX_C) begin
                            // Over-long pulse: drop the frame and wait for a fresh latch gap
                            error        <= 1'b1;
                            fault_seen_r <= 1'b1;
                            shift_r      <= 7'd0;
                            bit_cnt_r    <= 3'd0;
                            byte_cnt_r   <= 14'd0;
                            cnt_r        <= '0;
                            state_r      <= ST_SYNC;
                            busy         <= 1'b0;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end else begin
                        shift_r   <= {shift_r[5:0], bit_val_s};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            dataOut     <= {shift_r, bit_val_s};
                            byte_pend_r <= 1'b1;
                        end
                        state_r <= ST_LOW;
                        cnt_r   <= CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (line_s) begin
                        state_r <= ST_HIGH;
                        cnt_r   <= CNT_W'(1);
                    end else if (cnt_r >= LOW_LAST_C) begin
                        frameDone    <= 1'b1;
                        frameBytes   <= byte_cnt_r;
                        byte_cnt_r   <= 14'd0;
                        bit_cnt_r    <= 3'd0;
                        shift_r      <= 7'd0;
                        fault_seen_r <= 1'b0;
                        if (bit_cnt_r != 3'd0) begin
                            error         <= 1'b1;
                            frame_clean_r <= 1'b0;
                        end else begin
                            frame_clean_r <= ~fault_seen_r;
                        end
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Bench for anton_neopixel_decoder: directed frame table, reset corner cases, then random frames
// checked against a run-length reference model of the line protocol.
module tb_anton_neopixel_decoder;

    localparam int ONE_MIN   = 4;
    localparam int HIGH_MAX  = 12;
    localparam int RESET_LOW = 350;

    logic        clk7mhz = 1'b0;
    logic        reset;
    logic        neoData;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic [13:0] byteIndex;
    logic        frameDone;
    logic [13:0] frameBytes;
    logic        error;
    logic        busy;

    anton_neopixel_decoder #(
        .ONE_MIN(ONE_MIN), .HIGH_MAX(HIGH_MAX), .RESET_LOW(RESET_LOW), .CNT_W(10)
    ) dut (
        .clk7mhz(clk7mhz), .reset(reset), .neoData(neoData), .dataOut(dataOut),
        .dataValid(dataValid), .byteIndex(byteIndex), .frameDone(frameDone),
        .frameBytes(frameBytes), .error(error), .busy(busy)
    );

    always #5 clk7mhz = ~clk7mhz;

    int n_cmp  = 0;
    int n_fail = 0;

    // observed events
    logic [21:0] act_bytes[$];
    logic [13:0] act_frames[$];
    int          overlap = 0;

    always @(negedge clk7mhz) begin
        if (dataValid === 1'b1) act_bytes.push_back({byteIndex, dataOut});
        if (frameDone === 1'b1) act_frames.push_back(frameBytes);
        if (dataValid === 1'b1 && frameDone === 1'b1) overlap++;
    end

    // reference model: works on whole high/low runs of the line
    logic [21:0] exp_bytes[$];
    logic [13:0] exp_frames[$];
    bit          m_sync, m_inframe, m_err, m_faultp, m_lvl;
    int          m_len, m_nbits, m_bytes;
    logic [7:0]  m_acc;

    task automatic model_reset();
        m_sync = 0; m_inframe = 0; m_err = 0; m_faultp = 0; m_lvl = 0;
        m_len = 0; m_nbits = 0; m_bytes = 0; m_acc = 8'd0;
    endtask

    task automatic model_high(input int len);
        if (m_sync) begin
            if (len > HIGH_MAX) begin
                m_err = 1; m_faultp = 1; m_sync = 0; m_inframe = 0;
                m_nbits = 0; m_bytes = 0;
            end else begin
                m_acc = {m_acc[6:0], (len >= ONE_MIN) ? 1'b1 : 1'b0};
                m_nbits++;
                m_inframe = 1;
                if (m_nbits == 8) begin
                    exp_bytes.push_back({14'((m_bytes > 16383) ? 16383 : m_bytes), m_acc});
                    m_bytes++;
                    m_nbits = 0;
                end
            end
        end
    endtask

    task automatic model_gap();
        if (!m_sync) begin
            m_sync = 1;
        end else if (m_inframe) begin
            exp_frames.push_back(14'((m_bytes > 16383) ? 16383 : m_bytes));
            m_err = (m_nbits != 0) || m_faultp;
            m_faultp = 0; m_nbits = 0; m_bytes = 0; m_inframe = 0;
        end
    endtask

    task automatic model_feed(input logic lvl, input int n);
        if (lvl != m_lvl) begin
            if (m_lvl) model_high(m_len);
            m_lvl = lvl;
            m_len = 0;
        end
        if (!lvl && m_len < RESET_LOW && m_len + n >= RESET_LOW) model_gap();
        m_len += n;
    endtask

    task automatic run(input logic lvl, input int n);
        neoData = lvl;
        model_feed(lvl, n);
        repeat (n) begin
            @(posedge clk7mhz);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk7mhz);
            #1;
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_bits(input logic [23:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (data[i]) begin run(1'b1, 5); run(1'b0, 3); end
            else         begin run(1'b1, 2); run(1'b0, 6); end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        act_bytes.delete(); act_frames.delete(); exp_bytes.delete(); exp_frames.delete();
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " byte count"}, 32'(act_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < act_bytes.size() && i < exp_bytes.size(); i++)
            chk({tag, " byte idx/data"}, 32'(act_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, " frame count"}, 32'(act_frames.size()), 32'(exp_frames.size()));
        for (int i = 0; i < act_frames.size() && i < exp_frames.size(); i++)
            chk({tag, " frameBytes"}, 32'(act_frames[i]), 32'(exp_frames[i]));
        chk({tag, " error"}, 32'(error), 32'(m_err));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          nbits;
        logic [23:0] data;
        bit          fault;
        int          exp_valid;
        bit          exp_frame;
        int          exp_fbytes;
        bit          exp_err;
        bit          exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [23:0] d;
        int nb, hi;

        vecs[0] = '{8,  24'h0000A5, 1'b0, 1, 1'b1, 1, 1'b0, 1'b1};
        vecs[1] = '{24, 24'h123456, 1'b0, 3, 1'b1, 3, 1'b0, 1'b1};
        vecs[2] = '{4,  24'h000005, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0};
        vecs[3] = '{8,  24'h00003C, 1'b0, 1, 1'b1, 1, 1'b1, 1'b1};
        vecs[4] = '{8,  24'h000081, 1'b0, 1, 1'b1, 1, 1'b0, 1'b1};
        vecs[5] = '{5,  24'h000015, 1'b0, 0, 1'b1, 0, 1'b1, 1'b1};
        vecs[6] = '{16, 24'h00BEEF, 1'b0, 2, 1'b1, 2, 1'b0, 1'b1};

        neoData = 1'b0;
        model_reset();
        do_reset(3);
        chk("reset dataValid", 32'(dataValid), 32'd0);
        chk("reset frameDone", 32'(frameDone), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        run(1'b0, 400);
        chk("sync busy", 32'(busy), 32'd0);
        chk("sync error", 32'(error), 32'd0);
        chk("sync no events", 32'(act_bytes.size() + act_frames.size()), 32'd0);

        // directed frame table, applied back to back
        for (int v = 0; v < 7; v++) begin
            clear_q();
            send_bits(vecs[v].data, vecs[v].nbits);
            if (vecs[v].fault) run(1'b1, 20);
            run(1'b0, 5);
            chk("table busy in frame", 32'(busy), 32'(vecs[v].exp_busy));
            run(1'b0, 400);
            chk("table dataValid count", 32'(act_bytes.size()), 32'(vecs[v].exp_valid));
            for (int k = 0; k < vecs[v].exp_valid && k < act_bytes.size(); k++) begin
                d = vecs[v].data >> (vecs[v].nbits - 8 * (k + 1));
                chk("table byte idx/data", 32'(act_bytes[k]), 32'({14'(k), d[7:0]}));
            end
            chk("table frameDone count", 32'(act_frames.size()), 32'(vecs[v].exp_frame));
            if (act_frames.size() > 0)
                chk("table frameBytes", 32'(act_frames[0]), 32'(vecs[v].exp_fbytes));
            chk("table error", 32'(error), 32'(vecs[v].exp_err));
            chk("table busy after gap", 32'(busy), 32'd0);
        end

        // reset one cycle after bit 4, line keeps going: nothing decoded until a latch gap
        clear_q();
        send_bits(24'h0000F0, 4);
        run(1'b0, 2);
        do_reset(1);
        send_bits(24'h000000, 4);
        send_bits(24'h0000AA, 8);
        run(1'b0, 400);
        chk("midreset no dataValid", 32'(act_bytes.size()), 32'd0);
        chk("midreset no frameDone", 32'(act_frames.size()), 32'd0);
        chk("midreset error", 32'(error), 32'd0);
        send_bits(24'h00005A, 8);
        run(1'b0, 400);
        chk("midreset next byte count", 32'(act_bytes.size()), 32'd1);
        if (act_bytes.size() > 0) chk("midreset next byte", 32'(act_bytes[0]), 32'({14'd0, 8'h5A}));
        chk("midreset frameDone", 32'(act_frames.size()), 32'd1);

        // line held high from reset: stays in SYNC
        clear_q();
        neoData = 1'b1;
        do_reset(2);
        run(1'b1, 500);
        chk("held high busy", 32'(busy), 32'd0);
        chk("held high no events", 32'(act_bytes.size() + act_frames.size()), 32'd0);
        run(1'b0, 400);
        chk("held high then low busy", 32'(busy), 32'd0);

        // random frames against the model
        for (int f = 0; f < 30; f++) begin
            clear_q();
            nb = ($urandom_range(0, 1) == 0) ? 8 * $urandom_range(1, 3) : $urandom_range(1, 24);
            for (int b = 0; b < nb; b++) begin
                hi = ($urandom_range(0, 29) == 0) ? $urandom_range(13, 25) : $urandom_range(1, 12);
                run(1'b1, hi);
                run(1'b0, $urandom_range(1, 20));
            end
            run(1'b0, $urandom_range(360, 420));
            cmp_model("random");
        end

        chk("dataValid/frameDone overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
